// File: rtl/game_level_select_if.sv
// Switch/box-pickup inputs and level/bonus-box outputs between the board-facing
// selector and the maze/score/VGA logic.
interface game_level_select_if #(
    parameter int unsigned NUM_LEVELS = 3,
    parameter int unsigned COORD_W    = 5
);
    localparam int unsigned IDX_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

    logic [NUM_LEVELS-1:0] levelSw;
    logic                  plusTaken;
    logic                  minusTaken;
    logic [NUM_LEVELS-1:0] playLevel;
    logic [IDX_W-1:0]      levelIndex;
    logic                  levelStart;
    logic                  externalReset;
    logic                  selError;
    logic                  plusValid;
    logic                  minusValid;
    logic [COORD_W-1:0]    scorePlusFiveX;
    logic [COORD_W-1:0]    scorePlusFiveY;
    logic [COORD_W-1:0]    scoreMinusFiveX;
    logic [COORD_W-1:0]    scoreMinusFiveY;

    modport master (
        output levelSw, plusTaken, minusTaken,
        input  playLevel, levelIndex, levelStart, externalReset, selError,
               plusValid, minusValid, scorePlusFiveX, scorePlusFiveY,
               scoreMinusFiveX, scoreMinusFiveY
    );

    modport slave (
        input  levelSw, plusTaken, minusTaken,
        output playLevel, levelIndex, levelStart, externalReset, selError,
               plusValid, minusValid, scorePlusFiveX, scorePlusFiveY,
               scoreMinusFiveX, scoreMinusFiveY
    );
endinterface

// File: rtl/game_level_select.sv
// Registered level selector: synchronises the switches, qualifies a stable one-hot
// choice, locks it for the game and publishes the per-level bonus-box layout.
module game_level_select #(
    parameter int unsigned NUM_LEVELS    = 3,
    parameter int unsigned COORD_W       = 5,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter logic [NUM_LEVELS*COORD_W-1:0] PLUS_X_TAB  = {5'd10, 5'd17, 5'd13},
    parameter logic [NUM_LEVELS*COORD_W-1:0] PLUS_Y_TAB  = {5'd6,  5'd9,  5'd5},
    parameter logic [NUM_LEVELS*COORD_W-1:0] MINUS_X_TAB = {5'd15, 5'd4,  5'd10},
    parameter logic [NUM_LEVELS*COORD_W-1:0] MINUS_Y_TAB = {5'd19, 5'd6,  5'd3}
) (
    input logic                clock,
    input logic                resetn,
    game_level_select_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_QUALIFY, S_PLAY, S_FAULT} state_t;

    function automatic logic [IDX_W-1:0] oh_to_idx(input logic [NUM_LEVELS-1:0] oh);
        oh_to_idx = '0;
        for (int i = 0; i < NUM_LEVELS; i++)
            if (oh[i]) oh_to_idx = IDX_W'(i);
    endfunction

    function automatic logic [COORD_W-1:0] tab_sel(input logic [NUM_LEVELS*COORD_W-1:0] tab,
                                                   input logic [IDX_W-1:0] idx);
        tab_sel = '0;
        for (int i = 0; i < NUM_LEVELS; i++)
            if (idx == IDX_W'(i)) tab_sel = tab[i*COORD_W +: COORD_W];
    endfunction

    state_t                r_state, w_state_nxt;
    logic [NUM_LEVELS-1:0] r_sync1, r_sws;
    logic [NUM_LEVELS-1:0] r_cand, w_cand_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;

    logic [NUM_LEVELS-1:0] r_play_level, w_play_level_nxt;
    logic [IDX_W-1:0]      r_level_index, w_level_index_nxt;
    logic                  r_level_start, w_level_start_nxt;
    logic                  r_ext_reset, w_ext_reset_nxt;
    logic                  r_sel_error, w_sel_error_nxt;
    logic                  r_plus_valid, w_plus_valid_nxt;
    logic                  r_minus_valid, w_minus_valid_nxt;
    logic [COORD_W-1:0]    r_px, r_py, r_mx, r_my;
    logic [COORD_W-1:0]    w_px_nxt, w_py_nxt, w_mx_nxt, w_my_nxt;

    logic                  w_sws_zero, w_sws_onehot;
    logic [IDX_W-1:0]      w_cand_idx;

    assign w_sws_zero   = (r_sws == '0);
    assign w_sws_onehot = !w_sws_zero && ((r_sws & (r_sws - NUM_LEVELS'(1))) == '0);
    assign w_cand_idx   = oh_to_idx(r_cand);

    // Two-flop synchroniser for the asynchronous board switches
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '0;
            r_sws   <= '0;
        end else begin
            r_sync1 <= bus.levelSw;
            r_sws   <= r_sync1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_cand        <= '0;
            r_cnt         <= '0;
            r_play_level  <= '0;
            r_level_index <= '0;
            r_level_start <= 1'b0;
            r_ext_reset   <= 1'b1;
            r_sel_error   <= 1'b0;
            r_plus_valid  <= 1'b0;
            r_minus_valid <= 1'b0;
            r_px          <= '0;
            r_py          <= '0;
            r_mx          <= '0;
            r_my          <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cand        <= w_cand_nxt;
            r_cnt         <= w_cnt_nxt;
            r_play_level  <= w_play_level_nxt;
            r_level_index <= w_level_index_nxt;
            r_level_start <= w_level_start_nxt;
            r_ext_reset   <= w_ext_reset_nxt;
            r_sel_error   <= w_sel_error_nxt;
            r_plus_valid  <= w_plus_valid_nxt;
            r_minus_valid <= w_minus_valid_nxt;
            r_px          <= w_px_nxt;
            r_py          <= w_py_nxt;
            r_mx          <= w_mx_nxt;
            r_my          <= w_my_nxt;
        end
    end

    // Next state plus next value of every registered output
    always_comb begin
        w_state_nxt       = r_state;
        w_cand_nxt        = r_cand;
        w_cnt_nxt         = r_cnt;
        w_play_level_nxt  = '0;
        w_level_index_nxt = '0;
        w_level_start_nxt = 1'b0;
        w_ext_reset_nxt   = 1'b1;
        w_sel_error_nxt   = 1'b0;
        w_plus_valid_nxt  = 1'b0;
        w_minus_valid_nxt = 1'b0;
        w_px_nxt          = '0;
        w_py_nxt          = '0;
        w_mx_nxt          = '0;
        w_my_nxt          = '0;

        unique case (r_state)
            S_IDLE: begin
                if (w_sws_onehot) begin
                    w_state_nxt = S_QUALIFY;
                    w_cand_nxt  = r_sws;
                    w_cnt_nxt   = '0;
                end else if (!w_sws_zero) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_QUALIFY: begin
                if (w_sws_zero) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_sws_onehot) begin
                    w_state_nxt = S_FAULT;
                end else if (r_sws != r_cand) begin
                    w_cand_nxt = r_sws;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_PLAY;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PLAY: begin
                // Level is locked: only an all-clear ends the game
                if (w_sws_zero) w_state_nxt = S_IDLE;
            end
            S_FAULT: begin
                if (w_sws_zero) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt == S_PLAY) begin
            w_ext_reset_nxt = 1'b0;
            if (r_state != S_PLAY) begin
                w_play_level_nxt  = r_cand;
                w_level_index_nxt = w_cand_idx;
                w_level_start_nxt = 1'b1;
                w_plus_valid_nxt  = 1'b1;
                w_minus_valid_nxt = 1'b1;
                w_px_nxt          = tab_sel(PLUS_X_TAB,  w_cand_idx);
                w_py_nxt          = tab_sel(PLUS_Y_TAB,  w_cand_idx);
                w_mx_nxt          = tab_sel(MINUS_X_TAB, w_cand_idx);
                w_my_nxt          = tab_sel(MINUS_Y_TAB, w_cand_idx);
            end else begin
                w_play_level_nxt  = r_play_level;
                w_level_index_nxt = r_level_index;
                w_plus_valid_nxt  = r_plus_valid & ~bus.plusTaken;
                w_minus_valid_nxt = r_minus_valid & ~bus.minusTaken;
                w_px_nxt          = r_px;
                w_py_nxt          = r_py;
                w_mx_nxt          = r_mx;
                w_my_nxt          = r_my;
            end
        end

        if (w_state_nxt == S_FAULT) w_sel_error_nxt = 1'b1;
    end

    assign bus.playLevel       = r_play_level;
    assign bus.levelIndex      = r_level_index;
    assign bus.levelStart      = r_level_start;
    assign bus.externalReset   = r_ext_reset;
    assign bus.selError        = r_sel_error;
    assign bus.plusValid       = r_plus_valid;
    assign bus.minusValid      = r_minus_valid;
    assign bus.scorePlusFiveX  = r_px;
    assign bus.scorePlusFiveY  = r_py;
    assign bus.scoreMinusFiveX = r_mx;
    assign bus.scoreMinusFiveY = r_my;

endmodule

// File: tb/tb_game_level_select.sv
// Directed bench for game_level_select at default parameters with hand-computed
// expectations for qualification latency, level lock, box pickup, fault and reset.
module tb_game_level_select;
    logic clock;
    logic resetn;
    int   n_vec;
    int   n_err;

    game_level_select_if #(.NUM_LEVELS(3), .COORD_W(5)) bus ();

    game_level_select dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit after the last one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk_box(input string tag, input logic [4:0] px, input logic [4:0] py,
                           input logic [4:0] mx, input logic [4:0] my);
        chk({tag, "_px"}, 32'(bus.scorePlusFiveX),  32'(px));
        chk({tag, "_py"}, 32'(bus.scorePlusFiveY),  32'(py));
        chk({tag, "_mx"}, 32'(bus.scoreMinusFiveX), 32'(mx));
        chk({tag, "_my"}, 32'(bus.scoreMinusFiveY), 32'(my));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        resetn = 1'b0;
        bus.levelSw = 3'b000;
        bus.plusTaken = 1'b0;
        bus.minusTaken = 1'b0;
        tick(2);
        chk("rst_ext",   32'(bus.externalReset), 32'd1);
        chk("rst_play",  32'(bus.playLevel),     32'd0);
        chk("rst_err",   32'(bus.selError),      32'd0);
        chk("rst_pv",    32'(bus.plusValid),     32'd0);
        chk("rst_start", 32'(bus.levelStart),    32'd0);
        resetn = 1'b1;
        tick(2);

        // Easy level: 19 edges from switch change to playLevel
        bus.levelSw = 3'b001;
        tick(18);
        chk("easy_e18_play", 32'(bus.playLevel), 32'd0);
        chk("easy_e18_ext",  32'(bus.externalReset), 32'd1);
        tick(1);
        chk("easy_play",  32'(bus.playLevel),     32'd1);
        chk("easy_idx",   32'(bus.levelIndex),    32'd0);
        chk("easy_start", 32'(bus.levelStart),    32'd1);
        chk("easy_ext",   32'(bus.externalReset), 32'd0);
        chk("easy_pv",    32'(bus.plusValid),     32'd1);
        chk("easy_mv",    32'(bus.minusValid),    32'd1);
        chk_box("easy", 5'd13, 5'd5, 5'd10, 5'd3);
        tick(1);
        chk("easy_start_drop", 32'(bus.levelStart), 32'd0);
        chk("easy_play_hold",  32'(bus.playLevel),  32'd1);

        // Box pickup: plus alone, then both together
        bus.plusTaken = 1'b1;
        tick(1);
        bus.plusTaken = 1'b0;
        chk("take_p_pv", 32'(bus.plusValid),  32'd0);
        chk("take_p_mv", 32'(bus.minusValid), 32'd1);
        chk_box("take_p", 5'd13, 5'd5, 5'd10, 5'd3);
        tick(2);
        chk("take_p_stay", 32'(bus.plusValid), 32'd0);
        bus.plusTaken = 1'b1;
        bus.minusTaken = 1'b1;
        tick(1);
        bus.plusTaken = 1'b0;
        bus.minusTaken = 1'b0;
        chk("take_b_pv", 32'(bus.plusValid),  32'd0);
        chk("take_b_mv", 32'(bus.minusValid), 32'd0);
        chk("take_b_play", 32'(bus.playLevel), 32'd1);

        // Asynchronous reset mid-game, then replay with switch still held
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_play", 32'(bus.playLevel),     32'd0);
        chk("arst_ext",  32'(bus.externalReset), 32'd1);
        chk("arst_mv",   32'(bus.minusValid),    32'd0);
        #1;
        resetn = 1'b1;
        tick(18);
        chk("replay_e18", 32'(bus.playLevel), 32'd0);
        tick(1);
        chk("replay_play",  32'(bus.playLevel),  32'd1);
        chk("replay_start", 32'(bus.levelStart), 32'd1);
        chk("replay_pv",    32'(bus.plusValid),  32'd1);

        // End of game: two sync edges still playing, third edge idles
        bus.levelSw = 3'b000;
        tick(2);
        chk("end_e2_ext", 32'(bus.externalReset), 32'd0);
        tick(1);
        chk("end_ext",  32'(bus.externalReset),  32'd1);
        chk("end_play", 32'(bus.playLevel),      32'd0);
        chk("end_pv",   32'(bus.plusValid),      32'd0);
        chk("end_px",   32'(bus.scorePlusFiveX), 32'd0);

        // Hard held 10 cycles then medium: only medium qualifies
        bus.levelSw = 3'b100;
        tick(10);
        chk("short_hard", 32'(bus.playLevel), 32'd0);
        bus.levelSw = 3'b010;
        tick(18);
        chk("med_e18", 32'(bus.playLevel), 32'd0);
        tick(1);
        chk("med_play", 32'(bus.playLevel),  32'd2);
        chk("med_idx",  32'(bus.levelIndex), 32'd1);
        chk_box("med", 5'd17, 5'd9, 5'd4, 5'd6);
        bus.levelSw = 3'b000;
        tick(3);

        // Hard game, then multi-hot switch change is ignored
        bus.levelSw = 3'b100;
        tick(19);
        chk("hard_play", 32'(bus.playLevel),  32'd4);
        chk("hard_idx",  32'(bus.levelIndex), 32'd2);
        chk_box("hard", 5'd10, 5'd6, 5'd15, 5'd19);
        bus.levelSw = 3'b101;
        tick(5);
        chk("lock_play", 32'(bus.playLevel),     32'd4);
        chk("lock_err",  32'(bus.selError),      32'd0);
        chk("lock_ext",  32'(bus.externalReset), 32'd0);
        chk("lock_idx",  32'(bus.levelIndex),    32'd2);
        bus.levelSw = 3'b000;
        tick(3);

        // Illegal multi-hot from IDLE enters FAULT, exits only on all-clear
        bus.plusTaken = 1'b1;
        bus.levelSw = 3'b011;
        tick(2);
        bus.plusTaken = 1'b0;
        chk("flt_e2_err", 32'(bus.selError), 32'd0);
        chk("idle_pv",    32'(bus.plusValid), 32'd0);
        tick(1);
        chk("flt_err", 32'(bus.selError),      32'd1);
        chk("flt_ext", 32'(bus.externalReset), 32'd1);
        bus.levelSw = 3'b001;
        tick(25);
        chk("flt_hold_err",  32'(bus.selError),  32'd1);
        chk("flt_hold_play", 32'(bus.playLevel), 32'd0);
        bus.levelSw = 3'b000;
        tick(3);
        chk("flt_clear", 32'(bus.selError), 32'd0);
        bus.levelSw = 3'b001;
        tick(18);
        chk("post_flt_e18", 32'(bus.playLevel), 32'd0);
        tick(1);
        chk("post_flt_play", 32'(bus.playLevel), 32'd1);
        chk_box("post_flt", 5'd13, 5'd5, 5'd10, 5'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
